// File: rtl/traffic_junction_light.sv
// traffic_junction_light: four-way round-robin N->E->S->W lamp controller with green/yellow/all-red phases
module traffic_junction_light #(
    parameter int unsigned GREEN_CYCLES  = 5,
    parameter int unsigned YELLOW_CYCLES = 2,
    parameter int unsigned ALLRED_CYCLES = 1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    output logic N_RedLight,
    output logic N_YellowLight,
    output logic N_GreenLight,
    output logic E_RedLight,
    output logic E_YellowLight,
    output logic E_GreenLight,
    output logic S_RedLight,
    output logic S_YellowLight,
    output logic S_GreenLight,
    output logic W_RedLight,
    output logic W_YellowLight,
    output logic W_GreenLight
);
    typedef enum logic [3:0] {
        IDLE,
        N_GREEN, N_YELLOW, N_ALLRED,
        E_GREEN, E_YELLOW, E_ALLRED,
        S_GREEN, S_YELLOW, S_ALLRED,
        W_GREEN, W_YELLOW, W_ALLRED
    } state_t;
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_CYCLES - 1);
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic [3:0]       w_grn;
    logic [3:0]       w_yel;
    logic [3:0]       r_grn;
    logic [3:0]       r_yel;
    logic [3:0]       r_red;
    // state and lamp registers; lamps are decoded from the state being entered so they track r_state
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_grn   <= '0;
            r_yel   <= '0;
            r_red   <= '1;
        end else begin
            r_state <= w_next;
            r_grn   <= w_grn;
            r_yel   <= w_yel;
            r_red   <= ~(w_grn | w_yel);
        end
    end
    // phase timer restarts on every state entry and counts while a timed state dwells
    always_ff @(posedge CLK) begin
        if (RST || w_next != r_state)
            r_timer <= '0;
        else if (r_state != IDLE)
            r_timer <= r_timer + 1'b1;
    end
    // next state: phases advance on their last timer count; reset or disable drop to idle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:                                        w_next = N_GREEN;
            N_GREEN, E_GREEN, S_GREEN, W_GREEN:          w_next = (r_timer == G_LAST) ? state_t'(r_state + 4'd1) : r_state;
            N_YELLOW, E_YELLOW, S_YELLOW, W_YELLOW:      w_next = (r_timer == Y_LAST) ? state_t'(r_state + 4'd1) : r_state;
            N_ALLRED, E_ALLRED, S_ALLRED:                w_next = (r_timer == A_LAST) ? state_t'(r_state + 4'd1) : r_state;
            W_ALLRED:                                    w_next = (r_timer == A_LAST) ? N_GREEN : r_state;
            default:                                     w_next = IDLE;
        endcase
        if (RST || !EN)
            w_next = IDLE;
    end
    // lamp decode of the upcoming state, bit 0..3 = N, E, S, W
    always_comb begin
        w_grn = {w_next == W_GREEN,  w_next == S_GREEN,  w_next == E_GREEN,  w_next == N_GREEN};
        w_yel = {w_next == W_YELLOW, w_next == S_YELLOW, w_next == E_YELLOW, w_next == N_YELLOW};
    end
    assign N_RedLight    = r_red[0];
    assign N_YellowLight = r_yel[0];
    assign N_GreenLight  = r_grn[0];
    assign E_RedLight    = r_red[1];
    assign E_YellowLight = r_yel[1];
    assign E_GreenLight  = r_grn[1];
    assign S_RedLight    = r_red[2];
    assign S_YellowLight = r_yel[2];
    assign S_GreenLight  = r_grn[2];
    assign W_RedLight    = r_red[3];
    assign W_YellowLight = r_yel[3];
    assign W_GreenLight  = r_grn[3];
endmodule

// File: tb/tb_traffic_junction_light.sv
// tb_traffic_junction_light: scoreboard bench for default, fast and slow timing instances
module tb_traffic_junction_light;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic EN  = 1'b0;
    always #5 CLK = ~CLK;
    wire [11:0] l0, l1, l2;
    traffic_junction_light u0 (
        .CLK(CLK), .RST(RST), .EN(EN),
        .N_RedLight(l0[2]),  .N_YellowLight(l0[1]),  .N_GreenLight(l0[0]),
        .E_RedLight(l0[5]),  .E_YellowLight(l0[4]),  .E_GreenLight(l0[3]),
        .S_RedLight(l0[8]),  .S_YellowLight(l0[7]),  .S_GreenLight(l0[6]),
        .W_RedLight(l0[11]), .W_YellowLight(l0[10]), .W_GreenLight(l0[9])
    );
    traffic_junction_light #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(1)) u1 (
        .CLK(CLK), .RST(RST), .EN(EN),
        .N_RedLight(l1[2]),  .N_YellowLight(l1[1]),  .N_GreenLight(l1[0]),
        .E_RedLight(l1[5]),  .E_YellowLight(l1[4]),  .E_GreenLight(l1[3]),
        .S_RedLight(l1[8]),  .S_YellowLight(l1[7]),  .S_GreenLight(l1[6]),
        .W_RedLight(l1[11]), .W_YellowLight(l1[10]), .W_GreenLight(l1[9])
    );
    traffic_junction_light #(.GREEN_CYCLES(100), .YELLOW_CYCLES(20), .ALLRED_CYCLES(5)) u2 (
        .CLK(CLK), .RST(RST), .EN(EN),
        .N_RedLight(l2[2]),  .N_YellowLight(l2[1]),  .N_GreenLight(l2[0]),
        .E_RedLight(l2[5]),  .E_YellowLight(l2[4]),  .E_GreenLight(l2[3]),
        .S_RedLight(l2[8]),  .S_YellowLight(l2[7]),  .S_GreenLight(l2[6]),
        .W_RedLight(l2[11]), .W_YellowLight(l2[10]), .W_GreenLight(l2[9])
    );
    typedef struct packed {
        logic [11:0] exp;
        logic        run;
    } ent_t;
    localparam logic [11:0] ALL_RED = 12'b100_100_100_100;
    int   gc [3] = '{5, 1, 100};
    int   yc [3] = '{2, 1, 20};
    int   ac [3] = '{1, 1, 5};
    ent_t q0 [$];
    ent_t q1 [$];
    ent_t q2 [$];
    int   passed = 0;
    int   total  = 0;
    int   t      = 0;
    logic [11:0] prev     [3];
    logic        prev_run [3] = '{1'b0, 1'b0, 1'b0};
    function automatic logic [11:0] pat(input int d, input int ph);
        logic [11:0] v;
        v = ALL_RED;
        if (ph == 0) v[3*d +: 3] = 3'b001;
        else if (ph == 1) v[3*d +: 3] = 3'b010;
        return v;
    endfunction
    function automatic logic [11:0] sched(input int tt, input int g, input int y, input int a);
        int per;
        int r;
        per = g + y + a;
        r   = tt % per;
        return pat((tt / per) % 4, (r < g) ? 0 : ((r < g + y) ? 1 : 2));
    endfunction
    task automatic cyc(input logic r, input logic e);
        @(negedge CLK);
        RST = r;
        EN  = e;
        if (r || !e) begin
            q0.push_back({ALL_RED, 1'b0});
            q1.push_back({ALL_RED, 1'b0});
            q2.push_back({ALL_RED, 1'b0});
            t = 0;
        end else begin
            q0.push_back({sched(t, gc[0], yc[0], ac[0]), 1'b1});
            q1.push_back({sched(t, gc[1], yc[1], ac[1]), 1'b1});
            q2.push_back({sched(t, gc[2], yc[2], ac[2]), 1'b1});
            t++;
        end
    endtask
    task automatic chk(input int i, input ent_t e, input logic [11:0] v);
        int  n;
        logic ok;
        total++;
        if (v === e.exp) passed++;
        else $display("FAIL lamps dut%0d @%0t got %b exp %b", i, $time, v, e.exp);
        ok = 1'b1;
        n  = 0;
        for (int d = 0; d < 4; d++) begin
            if (!$onehot(v[3*d +: 3])) ok = 1'b0;
            if (v[3*d + 2] !== 1'b1) n++;
        end
        total++;
        if (ok) passed++;
        else $display("FAIL onehot dut%0d @%0t got %b exp one lamp per approach", i, $time, v);
        total++;
        if (n <= 1) passed++;
        else $display("FAIL nonred dut%0d @%0t got %0d non-red exp <=1", i, $time, n);
        if (e.run && prev_run[i]) begin
            for (int d = 0; d < 4; d++) begin
                if (prev[i][3*d] === 1'b1) begin
                    total++;
                    if (v[3*d] === 1'b1 || v[3*d + 1] === 1'b1) passed++;
                    else $display("FAIL greenfollow dut%0d @%0t got %b after %b exp same green or yellow", i, $time, v, prev[i]);
                end
            end
        end
        prev[i]     = v;
        prev_run[i] = e.run;
    endtask
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (q0.size() > 0) chk(0, q0.pop_front(), l0);
            if (q1.size() > 0) chk(1, q1.pop_front(), l1);
            if (q2.size() > 0) chk(2, q2.pop_front(), l2);
        end
    end
    initial begin
        cyc(1, 1);
        cyc(1, 1);
        cyc(0, 1);
        repeat (10) cyc(0, 0);
        repeat (34) cyc(0, 1);
        cyc(0, 0);
        repeat (14) cyc(0, 1);
        cyc(0, 0);
        cyc(0, 0);
        repeat (19) cyc(0, 1);
        cyc(1, 1);
        repeat (40) cyc(0, 1);
        cyc(0, 0);
        repeat (1510) cyc(0, 1);
        @(posedge CLK);
        #2;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
